// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle, WIDTH+1 cycles start-to-done.
// Signed operands are divided as magnitudes; quotient/remainder signs are restored on the final step.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, quot, dvsr;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;

  logic             accept, last_step, ge;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff, rem_nxt, quot_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  assign accept    = start && !flush && (state != RUN);
  assign last_step = (state == RUN) && (cnt == CNT_W'(1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The shifted partial remainder keeps its top bit so divisors above 2^(WIDTH-1) compare correctly.
  always_comb begin
    shifted  = {rem, quot[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvsr});
    diff     = shifted[WIDTH-1:0] - dvsr;
    rem_nxt  = ge ? diff : shifted[WIDTH-1:0];
    quot_nxt = {quot[WIDTH-2:0], ge};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem         <= '0;
      quot        <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        if (divisor == '0) begin
          hi          <= dividend;
          lo          <= '1;
          div_by_zero <= 1'b1;
        end else begin
          rem   <= '0;
          quot  <= dvd_mag;
          dvsr  <= dvs_mag;
          cnt   <= CNT_W'(WIDTH);
          q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg <= is_signed && dividend[WIDTH-1];
        end
      end else if (state == RUN) begin
        rem  <= rem_nxt;
        quot <= quot_nxt;
        cnt  <= cnt - CNT_W'(1);
        if (last_step) begin
          lo          <= q_neg ? -quot_nxt : quot_nxt;
          hi          <= r_neg ? -rem_nxt : rem_nxt;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed MIPS corner cases plus random operands against a plain-arithmetic model.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset, start, is_signed, flush;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // MIPS semantics: truncating quotient, remainder takes the dividend's sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h dbz=%b, required all zero",
               busy, done, hi, lo, div_by_zero);
    end
  endtask

  task automatic test_divide(input logic [31:0] a, input logic [31:0] b, input logic s, input string name);
    logic [31:0] eq, er;
    logic        ez;
    model(a, b, s, eq, er, ez);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    tick();
    start = 1'b0;
    if (!ez) begin
      for (int c = 1; c <= 32; c++) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy cycle %0d: busy=%b done=%b, required busy=1 done=0", name, c, busy, done);
        end
        tick();
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done pulse: done=%b busy=%b, required done=1 busy=0", name, done, busy);
    end
    n_checks++;
    if (lo !== eq || hi !== er || div_by_zero !== ez) begin
      n_fail++;
      $display("FAIL %s result: lo=%h hi=%h dbz=%b, required lo=%h hi=%h dbz=%b",
               name, lo, hi, div_by_zero, eq, er, ez);
    end
    last_hi = er; last_lo = eq;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return idle: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_directed();
    test_divide(32'd100, 32'd7, 1'b0, "udiv_100_7");
    test_divide(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
    test_divide(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
    test_divide(32'd5, 32'd0, 1'b0, "udiv_by_zero");
    test_divide(32'd5, 32'd0, 1'b1, "sdiv_by_zero");
    test_divide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_overflow");
    test_divide(32'hFFFF_FFFF, 32'd1, 1'b0, "udiv_max_1");
    test_divide(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "udiv_big_divisor");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : -$urandom_range(1, 100);
      endcase
      test_divide(a, b, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_back_to_back();
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_start busy cycle %0d: busy=%b done=%b", c, busy, done);
      end
      if (c == 10) begin
        start = 1'b1; dividend = 32'd55; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL ignore_start result: done=%b lo=%0d hi=%0d, required done=1 lo=14 hi=2", done, lo, hi);
    end
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 34; c <= 65; c++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b busy cycle %0d: busy=%b done=%b", c, busy, done);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || lo !== 32'd3 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b result: done=%b lo=%0d hi=%0d dbz=%b, required done=1 lo=3 hi=0 dbz=0",
               done, lo, hi, div_by_zero);
    end
    last_lo = 32'd3; last_hi = 32'd0;
    tick();
  endtask

  task automatic test_flush();
    bit saw_done;
    dividend = 32'd1000; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== last_hi || lo !== last_lo) begin
      n_fail++;
      $display("FAIL flush: busy=%b done=%b hi=%h lo=%h, required 0 0 hi=%h lo=%h",
               busy, done, hi, lo, last_hi, last_lo);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL flush_quiet: busy/done seen after flush, required none");
    end
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_start: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h dbz=%b, required all zero",
               busy, done, hi, lo, div_by_zero);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
